// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: state encoding, cause indices
// and the default vector table base address.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_EPC = 3'd1,
    READ     = 3'd2,
    CAPTURE  = 3'd3,
    LOAD_PC  = 3'd4
  } exc_state_e;

  localparam int unsigned CAUSE_OPCODE   = 0;
  localparam int unsigned CAUSE_OVERFLOW = 1;
  localparam int unsigned CAUSE_DIVZERO  = 2;

  localparam int unsigned DEFAULT_VEC_BASE = 253;

endpackage

// File: rtl/exc_sequencer_if.sv
// Request/memory/PC-load bundle between the exception sequencer (master) and
// the surrounding control path and memory (slave).
interface exc_sequencer_if #(
  parameter int unsigned NUM_CAUSES = 3,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_CAUSES-1:0] exc_req;
  logic                  busy;
  logic                  epc_write;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_rdata;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_value;
  logic [2:0]            cause_code;
  logic                  done;
  logic                  nested_err;

  modport master (
    input  exc_req, mem_rdata,
    output busy, epc_write, mem_read, mem_addr, pc_load, pc_value, cause_code, done,
           nested_err
  );

  modport slave (
    output exc_req, mem_rdata,
    input  busy, epc_write, mem_read, mem_addr, pc_load, pc_value, cause_code, done,
           nested_err
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over the exception request vector.
module exc_prio_enc #(
  parameter int unsigned NUM_CAUSES = 3
) (
  input  logic [NUM_CAUSES-1:0] req,
  output logic                  any,
  output logic [2:0]            idx
);

  assign any = |req;

  always_comb begin
    idx = 3'd0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception sub-FSM: save EPC, fetch the cause's vector byte, load PC with it.
// Outputs are decoded from registered state only.
module exc_sequencer import exc_pkg::*; #(
  parameter int unsigned NUM_CAUSES  = 3,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned VEC_BASE    = DEFAULT_VEC_BASE
) (
  input logic             clk,
  input logic             reset,
  exc_sequencer_if.master bus
);

  if (NUM_CAUSES < 1 || NUM_CAUSES > 8) begin : g_bad_causes
    $error("exc_sequencer: NUM_CAUSES must be 1..8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("exc_sequencer: MEM_LATENCY must be 1..15");
  end
  if (ADDR_WIDTH < 8) begin : g_bad_width
    $error("exc_sequencer: ADDR_WIDTH must hold a vector byte");
  end
  if (ADDR_WIDTH < 64 &&
      ((64'(VEC_BASE) + 64'(NUM_CAUSES) - 64'd1) >> ADDR_WIDTH) != 64'd0) begin : g_bad_base
    $error("exc_sequencer: vector table does not fit in ADDR_WIDTH");
  end

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  exc_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            cause_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  nested_q;

  logic                  req_any;
  logic [2:0]            req_idx;
  logic [ADDR_WIDTH-1:0] vec_addr;

  exc_prio_enc #(
    .NUM_CAUSES(NUM_CAUSES)
  ) u_prio (
    .req(bus.exc_req),
    .any(req_any),
    .idx(req_idx)
  );

  assign vec_addr = ADDR_WIDTH'(VEC_BASE) + ADDR_WIDTH'(cause_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (req_any) state_d = SAVE_EPC;
      SAVE_EPC: begin
        state_d = READ;
        cnt_d   = LAT_INIT;
      end
      READ: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE:  state_d = LOAD_PC;
      LOAD_PC:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Address is loaded on the way into READ so it holds after the sequence ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      cause_q  <= 3'd0;
      addr_q   <= '0;
      pc_q     <= '0;
      nested_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE && req_any)     cause_q  <= req_idx;
      if (state_q == SAVE_EPC)            addr_q   <= vec_addr;
      if (state_q == CAPTURE)             pc_q     <= ADDR_WIDTH'(bus.mem_rdata);
      if (state_q != IDLE && req_any)     nested_q <= 1'b1;
    end
  end

  logic busy, epc_write, mem_read, pc_load;

  always_comb begin
    busy      = 1'b0;
    epc_write = 1'b0;
    mem_read  = 1'b0;
    pc_load   = 1'b0;
    case (state_q)
      SAVE_EPC: begin
        busy      = 1'b1;
        epc_write = 1'b1;
      end
      READ, CAPTURE: begin
        busy     = 1'b1;
        mem_read = 1'b1;
      end
      LOAD_PC: begin
        busy    = 1'b1;
        pc_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy       = busy;
  assign bus.epc_write  = epc_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_addr   = addr_q;
  assign bus.pc_load    = pc_load;
  assign bus.done       = pc_load;
  assign bus.pc_value   = pc_q;
  assign bus.cause_code = cause_q;
  assign bus.nested_err = nested_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: three instances (latency 1, 2, 15) share one request
// stream; each is compared every cycle against a timeline model of the sequence.
module tb_exc_sequencer;
  import exc_pkg::*;

  localparam int unsigned NI = 3;
  localparam int unsigned VB = 253;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] exc_req = 3'b000;
  logic [7:0] vec_tab [3];

  logic [8:0]  o_ctrl [NI];
  logic [31:0] o_addr [NI];
  logic [31:0] o_pc   [NI];

  // Model: phase = cycles since acceptance, 0 when idle.
  int unsigned m_phase  [NI];
  logic [2:0]  m_cause  [NI];
  logic [31:0] m_addr   [NI];
  logic [31:0] m_pc     [NI];
  logic        m_nested [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int unsigned i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    if (a >= VB && a < VB + 3) return vec_tab[int'(a - VB)];
    return 8'h00;
  endfunction

  function automatic logic [2:0] lowest(input logic [2:0] r);
    for (int k = 0; k < 3; k++) if (r[k]) return 3'(k);
    return 3'd0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned L = lat_of(g);
    exc_sequencer_if #(.NUM_CAUSES(3), .ADDR_WIDTH(32)) bus ();
    exc_sequencer #(
      .NUM_CAUSES(3),
      .MEM_LATENCY(L),
      .ADDR_WIDTH(32),
      .VEC_BASE(VB)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );

    // Memory only returns the real byte once the read has been held L cycles.
    logic [4:0] rd_cnt;
    always @(posedge clk or posedge reset) begin
      if (reset)             rd_cnt <= 5'd0;
      else if (bus.mem_read) rd_cnt <= (rd_cnt == 5'd31) ? rd_cnt : rd_cnt + 5'd1;
      else                   rd_cnt <= 5'd0;
    end
    assign bus.exc_req   = exc_req;
    assign bus.mem_rdata = (bus.mem_read && rd_cnt >= 5'(L)) ? rom_byte(bus.mem_addr) : 8'h3C;
    assign o_ctrl[g] = {bus.busy, bus.epc_write, bus.mem_read, bus.pc_load, bus.done,
                        bus.nested_err, bus.cause_code};
    assign o_addr[g] = bus.mem_addr;
    assign o_pc[g]   = bus.pc_value;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_phase[i]  = 0;
      m_cause[i]  = 3'd0;
      m_addr[i]   = 32'd0;
      m_pc[i]     = 32'd0;
      m_nested[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [2:0] req);
    for (int i = 0; i < NI; i++) begin
      int unsigned l;
      l = lat_of(i);
      if (m_phase[i] == 0) begin
        if (req != 3'b000) begin
          m_phase[i] = 1;
          m_cause[i] = lowest(req);
        end
      end else begin
        if (req != 3'b000) m_nested[i] = 1'b1;
        if (m_phase[i] == 1) m_addr[i] = VB + 32'(m_cause[i]);
        if (m_phase[i] == l + 2) m_pc[i] = {24'd0, vec_tab[m_cause[i]]};
        m_phase[i] = (m_phase[i] == l + 3) ? 0 : m_phase[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int unsigned l, p;
      logic [8:0]  exp_ctrl;
      l = lat_of(i);
      p = m_phase[i];
      exp_ctrl = {p != 0, p == 1, (p >= 2 && p <= l + 2), p == l + 3, p == l + 3,
                  m_nested[i], m_cause[i]};
      check($sformatf("ctrl L=%0d t=%0t", l, $time), 64'(o_ctrl[i]), 64'(exp_ctrl));
      check($sformatf("mem_addr L=%0d t=%0t", l, $time), 64'(o_addr[i]), 64'(m_addr[i]));
      check($sformatf("pc_value L=%0d t=%0t", l, $time), 64'(o_pc[i]), 64'(m_pc[i]));
    end
  endtask

  task automatic tick(input logic [2:0] req);
    exc_req = req;
    @(posedge clk);
    model_edge(req);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(3'b000);
  endtask

  // Called at a falling edge; reset is raised mid-cycle and checked before any clock edge.
  task automatic apply_reset();
    exc_req = 3'b000;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    logic [2:0] r;
    vec_tab = '{8'h11, 8'hA4, 8'h33};
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    idle(2);

    // Single overflow request.
    tick(3'(1 << CAUSE_OVERFLOW));
    idle(20);

    // All causes at once: opcode wins, others dropped silently.
    tick(3'b111);
    idle(20);

    // Requests while busy, including one during the last busy cycle of latency 2.
    tick(3'(1 << CAUSE_OPCODE));
    tick(3'b000);
    tick(3'(1 << CAUSE_DIVZERO));
    tick(3'b000);
    tick(3'b000);
    tick(3'(1 << CAUSE_OVERFLOW));
    idle(20);

    // Reset in the middle of the read phase, then a clean sequence.
    tick(3'(1 << CAUSE_DIVZERO));
    tick(3'b000);
    tick(3'b000);
    apply_reset();
    idle(4);
    tick(3'(1 << CAUSE_OPCODE));
    idle(20);

    // Vector byte with the top bit set must be zero-extended.
    vec_tab = '{8'hFF, 8'hFF, 8'hFF};
    tick(3'(1 << CAUSE_DIVZERO));
    idle(20);

    // Back-to-back: second request in the first idle cycle after done (latency 2).
    apply_reset();
    vec_tab = '{8'h5E, 8'h81, 8'h07};
    tick(3'(1 << CAUSE_OVERFLOW));
    idle(5);
    tick(3'(1 << CAUSE_OPCODE));
    idle(20);

    // Random traffic with occasional resets and table updates.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        apply_reset();
      end else begin
        r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        if ($urandom_range(0, 15) == 0) vec_tab[$urandom_range(0, 2)] = 8'($urandom);
        tick(r);
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Parametrised exception sequencer for the multicycle MIPS control path. Replaces the hard-wired exception states (invalid opcode, overflow, wait, MDR load, PC load) with one sub-FSM.
- Handles NUM_CAUSES prioritised causes and a configurable memory read latency.
- Sequence: write EPC, read the cause's vector byte from memory at VEC_BASE+cause, load PC with the zero-extended byte.
- The main controller stalls while busy is high.

Parameters:
- NUM_CAUSES, 3, number of exception causes; legal range 1..8; index 0 has highest priority.
- MEM_LATENCY, 2, cycles from first mem_read/mem_addr assertion to valid mem_rdata; legal range 1..15.
- ADDR_WIDTH, 32, width of mem_addr and pc_value.
- VEC_BASE, 253, address of cause 0's vector byte; VEC_BASE+NUM_CAUSES-1 must fit in ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- exc_req  in  NUM_CAUSES  one-cycle request pulses, one bit per cause
- busy  out  1  high in every non-IDLE state
- epc_write  out  1  one-cycle strobe; datapath stores PC-4 into EPC
- mem_read  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  vector byte address
- mem_rdata  in  8  byte returned by memory
- pc_load  out  1  one-cycle strobe; PC <= pc_value
- pc_value  out  ADDR_WIDTH  zero-extended vector byte
- cause_code  out  3  index of the cause being serviced; held until the next exception
- done  out  1  one-cycle pulse, coincident with pc_load
- nested_err  out  1  sticky; set when a request arrives while busy

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: state IDLE; all outputs 0, including cause_code, pc_value and nested_err; latency counter 0.
- Reset mid-sequence aborts immediately. No pc_load is issued.
- All outputs are registered, Moore-style, decoded from the state register.
- States:
  - IDLE: if exc_req != 0, latch cause_code = lowest set index and go to SAVE_EPC. Otherwise stay.
  - SAVE_EPC: epc_write=1, busy=1. Go to READ; counter <= MEM_LATENCY-1.
  - READ: mem_read=1, mem_addr = VEC_BASE + cause_code (zero-extended, ADDR_WIDTH-bit add, no wrap possible by parameter rule). Decrement counter; when counter==0, go to CAPTURE.
  - CAPTURE: mem_read and mem_addr held. Latch pc_value = {zeros, mem_rdata}. Go to LOAD_PC.
  - LOAD_PC: pc_load=1, done=1, mem_read=0. Go to IDLE.
- mem_addr holds its last value outside READ/CAPTURE. It is 0 only after reset.
- Latency: request sampled at cycle t gives epc_write at t+1, pc_load/done at t+3+MEM_LATENCY, and IDLE at t+4+MEM_LATENCY.
- Multiple bits set in one cycle: the lowest index is serviced; the other bits are dropped without setting nested_err.
- Any nonzero exc_req in a non-IDLE state (LOAD_PC included) sets nested_err. The request is otherwise ignored.
- Requests are never queued.
- The counter width is 4 bits. MEM_LATENCY=1 gives exactly one READ cycle.
- Illegal parameters are caught by an elaboration-time check ($error in a generate block).

Decomposition:
- Shared package exc_pkg holds:
  - state encoding constants: IDLE, SAVE_EPC, READ, CAPTURE, LOAD_PC;
  - cause index constants: CAUSE_OPCODE=0, CAUSE_OVERFLOW=1, CAUSE_DIVZERO=2;
  - default VEC_BASE.
- One natural sub-module, exc_prio_enc: parametrised lowest-index priority encoder with outputs any and idx[2:0]; purely combinational.

Test Plan:
- Reset, then exc_req=3'b010 (overflow), MEM_LATENCY=2, memory returns 8'hA4 → epc_write at t+1; mem_addr=254 in READ; pc_load/done at t+5 with pc_value=32'h000000A4; cause_code=1; busy low at t+6.
- exc_req=3'b111 in one cycle → cause_code=0, mem_addr=253, nested_err stays 0.
- Request pulse during READ and another during LOAD_PC → nested_err=1 and stays 1; the first sequence completes unchanged; no second epc_write.
- reset asserted in the middle of READ → all outputs 0 in the same cycle; no pc_load afterwards; a new request then completes normally.
- MEM_LATENCY=1 and MEM_LATENCY=15 with memory returning 8'hFF → pc_load at t+4 and t+18 respectively; pc_value=32'h000000FF (no sign extension).
- Back-to-back: a new request in the first IDLE cycle after done → accepted; second epc_write 1 cycle later; nested_err=0.
